instr_sequencer: RTL and testbench

- Producer side of the 16-bit TPU instruction stream.
- The host loads a short program into a local instruction buffer, then pulses start.
- The block issues one instruction per cycle on a registered bus that feeds the instruction decoder.
- It inserts bubbles for stalls and WAIT delays, stops on HALT or end of program, and reports completion.

---
 rtl/tpu_isa_pkg.sv | 40 ++++
 rtl/instr_buffer.sv | 52 +++++
 rtl/instr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// ---------------------------------------------------------------------------
// tpu_isa_pkg
// Shared constants for the 16-bit TPU instruction stream. The sequencer uses
// them now and the instruction decoder is meant to move onto the same set.
//   Word layout : [15:13] opcode, [12:0] immediate
//   Opcodes     : NOP, LOAD_ADDR, LOAD_WEIGHT, LOAD_INPUTS, VALID, WAIT,
//                 reserved (110), HALT
//   Also holds the sequencer state enum and small field-extract helpers.
// ---------------------------------------------------------------------------
package tpu_isa_pkg;

    localparam int OPC_W   = 3;
    localparam int IMM_W   = 13;
    localparam int INSTR_W = 16;

    localparam logic [OPC_W-1:0] OP_NOP         = 3'b000;
    localparam logic [OPC_W-1:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [OPC_W-1:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [OPC_W-1:0] OP_LOAD_INPUTS = 3'b011;
    localparam logic [OPC_W-1:0] OP_VALID       = 3'b100;
    localparam logic [OPC_W-1:0] OP_WAIT        = 3'b101;
    localparam logic [OPC_W-1:0] OP_RSVD        = 3'b110;
    localparam logic [OPC_W-1:0] OP_HALT        = 3'b111;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_WAITING,
        SEQ_FINISH
    } seq_state_e;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: OPC_W];
    endfunction

    function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] w);
        return w[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// ---------------------------------------------------------------------------
// instr_buffer
// DEPTH x 16 register array that the host fills in order. Holds the append
// pointer (count), a full flag, a clear, and a combinational read port.
//   clk, reset : clock, synchronous active-high reset (resets count only)
//   clear      : drop all entries (count <= 0), wins over a same-cycle append
//   append     : write wr_data at slot count and advance count
//   rd_addr    : read slot index; rd_data is combinational from the array
//   count      : number of valid entries, AW+1 bits so DEPTH is representable
//   full       : count == DEPTH
// ---------------------------------------------------------------------------
module instr_buffer
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               append,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data,
    output logic [AW:0]        count,
    output logic               full
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the pointer is. A reset or a
    // clear makes the old words unreachable, so their values never matter.
    always_ff @(posedge clk) begin
        if (!reset && !clear && append && !full) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    // Append pointer: clear beats append so the host can restart a load in
    // one cycle without worrying about a stray strobe.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (append && !full) begin
            count <= count + (AW+1)'(1);
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Producer side of the TPU instruction stream. The host loads a program into
// instr_buffer, pulses start, and the sequencer issues one instruction per
// cycle on a registered bus, inserting bubbles for stalls and WAITs, stopping
// on HALT or end of program and pulsing done.
//   clk, reset            : clock, synchronous active-high reset
//   prog_valid/prog_ready : host write handshake, prog_data is the word
//   prog_clear            : empty the buffer and clear error (IDLE only)
//   start                 : begin issuing from slot 0 (IDLE only)
//   stall                 : decoder cannot take an instruction this cycle
//   instr/instr_valid     : registered instruction bus, 0 means NOP/bubble
//   pc                    : next slot to fetch
//   busy, done, error     : status (done is a one-cycle pulse, error sticky)
// ---------------------------------------------------------------------------
module instr_sequencer
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               prog_clear,
    input  logic               start,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [AW:0] PC_ONE = (AW+1)'(1);

    seq_state_e         state, state_next;
    logic [INSTR_W-1:0] instr_next;
    logic               instr_valid_next;
    logic [AW:0]        pc_q, pc_next, pc_inc;
    logic [IMM_W-1:0]   wait_cnt, wait_cnt_next;
    logic               error_next, done_next, busy_next;
    logic               buf_append, buf_clear, buf_full;
    logic [AW:0]        count;
    logic [INSTR_W-1:0] fetch_word;
    logic [OPC_W-1:0]   opcode;
    logic [IMM_W-1:0]   imm;

    instr_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .clear   (buf_clear),
        .append  (buf_append),
        .wr_data (prog_data),
        .rd_addr (pc_q[AW-1:0]),
        .rd_data (fetch_word),
        .count   (count),
        .full    (buf_full)
    );

    // pc is kept one bit wider internally so "every slot issued" is simply
    // pc == count, even when the program fills all DEPTH slots.
    assign pc_inc     = pc_q + PC_ONE;
    assign opcode     = instr_opcode(fetch_word);
    assign imm        = instr_imm(fetch_word);
    assign pc         = pc_q[AW-1:0];
    assign prog_ready = !reset && (state == SEQ_IDLE) && !buf_full;

    // Next-state and next-output logic. Everything defaults to "bubble, hold"
    // so each state only spells out what it changes. busy and done are the
    // registered view of the current state, which makes done appear the cycle
    // after the last issued word and busy drop one cycle after that.
    always_comb begin
        state_next       = state;
        instr_next       = '0;
        instr_valid_next = 1'b0;
        pc_next          = pc_q;
        wait_cnt_next    = wait_cnt;
        error_next       = error;
        done_next        = (state == SEQ_FINISH);
        busy_next        = (state != SEQ_IDLE);
        buf_append       = 1'b0;
        buf_clear        = 1'b0;

        case (state)
            SEQ_IDLE: begin
                // A clear in the same cycle as start wins, so a run never
                // begins on a buffer that is being emptied underneath it.
                if (prog_clear) begin
                    buf_clear  = 1'b1;
                    error_next = 1'b0;
                end else begin
                    if (prog_valid) begin
                        if (buf_full) begin
                            error_next = 1'b1;
                        end else begin
                            buf_append = 1'b1;
                        end
                    end
                    if (start) begin
                        if (count != '0) begin
                            pc_next    = '0;
                            state_next = SEQ_RUN;
                        end else begin
                            state_next = SEQ_FINISH;
                        end
                    end
                end
            end

            SEQ_RUN: begin
                // A stall produces a bubble rather than repeating the last
                // word: decoder flags are single-cycle pulses.
                if (!stall) begin
                    pc_next = pc_inc;
                    case (opcode)
                        OP_WAIT: begin
                            if (imm >= IMM_W'(2)) begin
                                wait_cnt_next = imm - IMM_W'(1);
                                state_next    = SEQ_WAITING;
                            end
                        end
                        OP_HALT: begin
                            state_next = SEQ_FINISH;
                        end
                        OP_RSVD: begin
                            error_next = 1'b1;
                        end
                        default: begin
                            instr_next       = fetch_word;
                            instr_valid_next = 1'b1;
                        end
                    endcase
                    if (state_next == SEQ_RUN && pc_inc == count) begin
                        state_next = SEQ_FINISH;
                    end
                end
            end

            SEQ_WAITING: begin
                // The WAIT fetch cycle already produced one zero, so the
                // counter covers the remaining n-1 and ignores stall.
                wait_cnt_next = wait_cnt - IMM_W'(1);
                if (wait_cnt == IMM_W'(1)) begin
                    state_next = (pc_q == count) ? SEQ_FINISH : SEQ_RUN;
                end
            end

            SEQ_FINISH: begin
                state_next = SEQ_IDLE;
            end

            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    // State and output registers. Reset returns to IDLE with every output
    // low; the buffer pointer is reset inside instr_buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEQ_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_q        <= '0;
            wait_cnt    <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            instr       <= instr_next;
            instr_valid <= instr_valid_next;
            pc_q        <= pc_next;
            wait_cnt    <= wait_cnt_next;
            error       <= error_next;
            done        <= done_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. A behavioural model turns the loaded
// program and a per-cycle stall pattern into the expected bus trace; a
// compare process checks instr/instr_valid/done/busy against it every cycle,
// and literal sequences pin the model on the hand-worked programs.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int TB_DEPTH = 8;
    localparam int TB_AW    = 3;

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        done;
        logic        busy;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              prog_valid;
    logic              prog_ready;
    logic [15:0]       prog_data;
    logic              prog_clear;
    logic              start;
    logic              stall;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [TB_AW-1:0]  pc;
    logic              busy;
    logic              done;
    logic              error;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] progQ[$];
    logic [15:0] wantQ[$];
    logic [15:0] obsQ[$];
    exp_t        expQ[$];
    logic        modelErr = 1'b0;
    bit          armed    = 1'b0;
    int          doneIdx;
    int          obsIdx;

    instr_sequencer #(
        .DEPTH (TB_DEPTH),
        .AW    (TB_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_data   (prog_data),
        .prog_clear  (prog_clear),
        .start       (start),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    function automatic void pushExp(input logic [15:0] i, input logic v,
                                    input logic d, input logic b);
        exp_t e;
        e.instr = i;
        e.valid = v;
        e.done  = d;
        e.busy  = b;
        expQ.push_back(e);
    endfunction

    // Model: walk the program as the instruction set describes it. Entry 0 is
    // the bus two cycles after start; a fetch in cycle t shows up at t+1.
    task automatic buildExpect(input logic [63:0] stallMask);
        int          t;
        int          i;
        int          k;
        logic [15:0] w;
        logic [2:0]  op;
        bit          halted;
        expQ.delete();
        t      = 1;
        i      = 0;
        halted = 0;
        while (i < progQ.size() && !halted) begin
            if (t < 64 && stallMask[t]) begin
                pushExp(16'h0000, 1'b0, 1'b0, 1'b1);
                t++;
            end else begin
                w  = progQ[i];
                i++;
                op = w[15:13];
                if (op <= 3'd4) begin
                    pushExp(w, 1'b1, 1'b0, 1'b1);
                    t++;
                end else if (op == 3'd5) begin
                    k = (w[12:0] == 13'd0) ? 1 : int'(w[12:0]);
                    for (int j = 0; j < k; j++) pushExp(16'h0000, 1'b0, 1'b0, 1'b1);
                    t += k;
                end else if (op == 3'd6) begin
                    pushExp(16'h0000, 1'b0, 1'b0, 1'b1);
                    modelErr = 1'b1;
                    t++;
                end else begin
                    pushExp(16'h0000, 1'b0, 1'b0, 1'b1);
                    t++;
                    halted = 1;
                end
            end
        end
        pushExp(16'h0000, 1'b0, 1'b1, 1'b1);
        pushExp(16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle compare against the model while a run is armed.
    always @(negedge clk) begin
        if (armed && expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput($sformatf("instr[%0d]", obsIdx), instr, e.instr);
            checkOutput($sformatf("instr_valid[%0d]", obsIdx), instr_valid, e.valid);
            checkOutput($sformatf("done[%0d]", obsIdx), done, e.done);
            checkOutput($sformatf("busy[%0d]", obsIdx), busy, e.busy);
            obsQ.push_back(instr);
            if (done) doneIdx = obsIdx;
            obsIdx++;
        end
    end

    // Clear the buffer and append progQ, one word per cycle.
    task automatic loadProgram();
        @(posedge clk); #1;
        prog_clear = 1'b1;
        @(posedge clk); #1;
        prog_clear = 1'b0;
        modelErr   = 1'b0;
        foreach (progQ[k]) begin
            prog_valid = 1'b1;
            prog_data  = progQ[k];
            @(posedge clk); #1;
        end
        prog_valid = 1'b0;
    endtask

    // Pulse start, drive stall per cycle, let the compare process consume
    // the expected trace; a trace that is never consumed is a failure.
    task automatic applyStimulus(input logic [63:0] stallMask);
        buildExpect(stallMask);
        obsQ.delete();
        doneIdx = -1;
        obsIdx  = 0;
        @(posedge clk); #1;
        start = 1'b1;
        stall = stallMask[0];
        @(posedge clk); #1;
        start = 1'b0;
        stall = stallMask[1];
        @(posedge clk); #1;
        stall = stallMask[2];
        armed = 1'b1;
        for (int c = 3; c < 300 && expQ.size() > 0; c++) begin
            @(posedge clk); #1;
            stall = (c < 64) ? stallMask[c] : 1'b0;
        end
        armed = 1'b0;
        stall = 1'b0;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL run_timeout: %0d expected cycles never observed", expQ.size());
        end
        @(negedge clk);
        checkOutput("error_after_run", error, modelErr);
    endtask

    // Literal pins: observed bus prefix and the index where done appeared.
    task automatic checkSeq(input string name, input int wantDone);
        foreach (wantQ[k]) begin
            if (k < obsQ.size())
                checkOutput($sformatf("%s_seq[%0d]", name, k), obsQ[k], wantQ[k]);
            else
                checkOutput($sformatf("%s_seq_missing[%0d]", name, k), 32'hFFFF_FFFF, wantQ[k]);
        end
        checkOutput($sformatf("%s_done_idx", name), doneIdx, wantDone);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        prog_valid = 1'b0;
        prog_data  = 16'h0000;
        prog_clear = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("prog_ready_in_reset", prog_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_instr", instr, 16'h0000);
        checkOutput("rst_instr_valid", instr_valid, 1'b0);
        checkOutput("rst_pc", pc, 3'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_prog_ready", prog_ready, 1'b1);

        $display("[TB] straight-line program");
        progQ = '{16'h2005, 16'h4000, 16'h6000, 16'h8000};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h2005, 16'h4000, 16'h6000, 16'h8000, 16'h0000, 16'h0000};
        checkSeq("plain", 4);

        $display("[TB] WAIT 3");
        progQ = '{16'h4000, 16'hA003, 16'h8000};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        checkSeq("wait3", 5);

        $display("[TB] HALT");
        progQ = '{16'h4000, 16'hE000, 16'h8000};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h4000, 16'h0000, 16'h0000};
        checkSeq("halt", 2);
        checkOutput("halt_pc", pc, 3'd2);

        $display("[TB] stall after first issue");
        progQ = '{16'h4000, 16'h6000, 16'h8000};
        loadProgram();
        applyStimulus(64'b1100);
        wantQ = '{16'h4000, 16'h0000, 16'h0000, 16'h6000, 16'h8000};
        checkSeq("stall", 5);

        $display("[TB] WAIT 0 and WAIT 1");
        progQ = '{16'hA000, 16'hA001, 16'h4000};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h0000, 16'h0000, 16'h4000};
        checkSeq("wait01", 3);

        $display("[TB] WAIT as last slot");
        progQ = '{16'h4000, 16'hA002};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h4000, 16'h0000, 16'h0000};
        checkSeq("waitlast", 3);

        $display("[TB] fill, overflow, clear");
        progQ.delete();
        loadProgram();
        for (int k = 0; k < TB_DEPTH; k++) begin
            prog_valid = 1'b1;
            prog_data  = 16'h2100 + 16'(k);
            @(posedge clk); #1;
        end
        prog_valid = 1'b0;
        @(negedge clk);
        checkOutput("full_prog_ready", prog_ready, 1'b0);
        checkOutput("full_error", error, 1'b0);
        @(posedge clk); #1;
        prog_valid = 1'b1;
        prog_data  = 16'h2222;
        @(posedge clk); #1;
        prog_valid = 1'b0;
        @(negedge clk);
        checkOutput("overflow_error", error, 1'b1);
        @(posedge clk); #1;
        prog_clear = 1'b1;
        @(posedge clk); #1;
        prog_clear = 1'b0;
        modelErr   = 1'b0;
        @(negedge clk);
        checkOutput("clear_error", error, 1'b0);
        checkOutput("clear_prog_ready", prog_ready, 1'b1);

        $display("[TB] full buffer with reserved opcode");
        progQ = '{16'h2001, 16'h4002, 16'hC000, 16'h6003,
                  16'h8004, 16'h0000, 16'h2005, 16'h4006};
        loadProgram();
        applyStimulus(64'd0);
        wantQ = '{16'h2001, 16'h4002, 16'h0000, 16'h6003,
                  16'h8004, 16'h0000, 16'h2005, 16'h4006};
        checkSeq("rsvd", 8);
        checkOutput("rsvd_error", error, 1'b1);

        $display("[TB] reset during WAIT");
        progQ = '{16'hA00A, 16'h4000};
        loadProgram();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        modelErr = 1'b0;
        progQ.delete();
        @(negedge clk);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_instr", instr, 16'h0000);
        checkOutput("midrst_valid", instr_valid, 1'b0);
        checkOutput("midrst_pc", pc, 3'd0);
        checkOutput("midrst_error", error, 1'b0);

        $display("[TB] start with empty buffer");
        applyStimulus(64'd0);
        wantQ = '{16'h0000, 16'h0000};
        checkSeq("empty", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
